// File: rtl/mem_responder.sv
// Word-addressed 32-bit memory slave: WAIT_STATES+1 edges from accept to done, then a done cycle.
// No backpressure or queueing; strobes are sampled only in IDLE, and a held strobe is retaken after DONE.
`timescale 1ns/1ps
module mem_responder #(
  parameter int DEPTH       = 512,
  parameter int ADDR_W      = 9,
  parameter int WAIT_STATES = 2
) (
  input  logic        clock,
  input  logic        clear,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  localparam logic [31:0] DEPTH_W = 32'(DEPTH);
  localparam logic [3:0]  WS_INIT = 4'(WAIT_STATES);

  state_t            state;
  logic [3:0]        cnt;
  logic [31:0]       addr_q;
  logic [31:0]       wdata_q;
  logic              op_write;
  logic [31:0]       mem [DEPTH];

  logic              in_range;
  logic [ADDR_W-1:0] idx;
  logic              access;
  logic              mem_we;

  assign in_range = (addr_q < DEPTH_W);
  assign idx      = addr_q[ADDR_W-1:0];
  assign access   = (state == WAIT) && (cnt == 4'd0);
  // clear on the access edge aborts the write along with the rest of the request
  assign mem_we   = access && op_write && in_range && !clear;

  always_ff @(posedge clock) begin
    if (mem_we) begin
      mem[idx] <= wdata_q;
    end
  end

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      cnt   <= 4'd0;
      rdata <= 32'd0;
      done  <= 1'b0;
      busy  <= 1'b0;
      err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          err  <= 1'b0;
          if (Read && Write) begin
            state <= DONE;
            done  <= 1'b1;
            busy  <= 1'b1;
            err   <= 1'b1;
            rdata <= 32'd0;
          end else if (Read || Write) begin
            addr_q   <= addr;
            wdata_q  <= wdata;
            op_write <= Write;
            cnt      <= WS_INIT;
            state    <= WAIT;
            busy     <= 1'b1;
          end else begin
            busy <= 1'b0;
          end
        end
        WAIT: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            state <= DONE;
            done  <= 1'b1;
            if (!in_range) begin
              err   <= 1'b1;
              rdata <= 32'd0;
            end else if (!op_write) begin
              rdata <= mem[idx];
            end
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          done  <= 1'b0;
          err   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: one instance at WAIT_STATES=2, one at WAIT_STATES=0.
`timescale 1ns/1ps
module tb_mem_responder;

  logic        clk;
  logic        clear;
  logic        rd, wr;
  logic [31:0] addr, wdata, rdata;
  logic        done, busy, err;
  logic        rd0, wr0;
  logic [31:0] addr0, wdata0, rdata0;
  logic        done0, busy0, err0;

  int checks   = 0;
  int failures = 0;

  mem_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_STATES(2)) dut (
    .clock(clk), .clear(clear), .Read(rd), .Write(wr), .addr(addr), .wdata(wdata),
    .rdata(rdata), .done(done), .busy(busy), .err(err)
  );

  mem_responder #(.DEPTH(512), .ADDR_W(9), .WAIT_STATES(0)) dut0 (
    .clock(clk), .clear(clear), .Read(rd0), .Write(wr0), .addr(addr0), .wdata(wdata0),
    .rdata(rdata0), .done(done0), .busy(busy0), .err(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One request on the WAIT_STATES=2 instance; lat counts edges after the accept edge until done is seen.
  task automatic do_req(input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [31:0] rv, output logic ev,
                        output logic dn_next, output logic bz_next);
    rd = r; wr = w; addr = a; wdata = d;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b0;
    lat = 0;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    rv = rdata;
    ev = err;
    @(posedge clk); #1;
    dn_next = done;
    bz_next = busy;
  endtask

  task automatic test_reset();
    clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h want=0", rdata); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", done); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b want=0", busy); end
    checks++; if (err !== 1'b0) begin failures++; $display("FAIL reset_err got=%b want=0", err); end
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0) begin failures++; $display("FAIL reset_dut0 busy=%b done=%b want=0,0", busy0, done0); end
    clear = 1'b0;
  endtask

  task automatic test_write_read();
    int lat; logic [31:0] rv; logic ev, dn, bz;
    do_req(1'b0, 1'b1, 32'd5, 32'hDEADBEEF, lat, rv, ev, dn, bz);
    checks++; if (lat !== 3) begin failures++; $display("FAIL wr_latency got=%0d want=3", lat); end
    checks++; if (ev !== 1'b0) begin failures++; $display("FAIL wr_err got=%b want=0", ev); end
    checks++; if (dn !== 1'b0 || bz !== 1'b0) begin failures++; $display("FAIL wr_one_cycle done=%b busy=%b want=0,0", dn, bz); end
    do_req(1'b1, 1'b0, 32'd5, 32'd0, lat, rv, ev, dn, bz);
    checks++; if (rv !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_data got=%h want=deadbeef", rv); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL rd_latency got=%0d want=3", lat); end
    checks++; if (dn !== 1'b0) begin failures++; $display("FAIL rd_one_cycle done=%b want=0", dn); end
    checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_hold got=%h want=deadbeef", rdata); end
    do_req(1'b0, 1'b1, 32'd6, 32'h77, lat, rv, ev, dn, bz);
    checks++; if (rv !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_keeps_rdata got=%h want=deadbeef", rv); end
  endtask

  task automatic test_out_of_range();
    int lat; logic [31:0] rv; logic ev, dn, bz;
    do_req(1'b1, 1'b0, 32'd512, 32'd0, lat, rv, ev, dn, bz);
    checks++; if (ev !== 1'b1) begin failures++; $display("FAIL oor_rd_err got=%b want=1", ev); end
    checks++; if (rv !== 32'd0) begin failures++; $display("FAIL oor_rd_data got=%h want=0", rv); end
    checks++; if (lat !== 3) begin failures++; $display("FAIL oor_rd_latency got=%0d want=3", lat); end
    do_req(1'b0, 1'b1, 32'h80000005, 32'd1, lat, rv, ev, dn, bz);
    checks++; if (ev !== 1'b1) begin failures++; $display("FAIL oor_wr_err got=%b want=1", ev); end
    checks++; if (dn !== 1'b0) begin failures++; $display("FAIL oor_err_pulse done=%b want=0", dn); end
    do_req(1'b1, 1'b0, 32'd5, 32'd0, lat, rv, ev, dn, bz);
    checks++; if (rv !== 32'hDEADBEEF || ev !== 1'b0) begin failures++; $display("FAIL oor_mem5 got=%h err=%b want=deadbeef,0", rv, ev); end
  endtask

  task automatic test_dual_strobe();
    int lat; logic [31:0] rv; logic ev, dn, bz;
    do_req(1'b0, 1'b1, 32'd7, 32'hCAFE0007, lat, rv, ev, dn, bz);
    do_req(1'b1, 1'b1, 32'd7, 32'h1234, lat, rv, ev, dn, bz);
    checks++; if (ev !== 1'b1) begin failures++; $display("FAIL dual_err got=%b want=1", ev); end
    checks++; if (lat !== 0) begin failures++; $display("FAIL dual_latency got=%0d want=0", lat); end
    checks++; if (rv !== 32'd0) begin failures++; $display("FAIL dual_rdata got=%h want=0", rv); end
    do_req(1'b1, 1'b0, 32'd7, 32'd0, lat, rv, ev, dn, bz);
    checks++; if (rv !== 32'hCAFE0007) begin failures++; $display("FAIL dual_mem7 got=%h want=cafe0007", rv); end
  endtask

  task automatic test_busy_ignore();
    int lat; logic [31:0] rv; logic ev, dn, bz;
    rd = 1'b1; addr = 32'd5;
    @(posedge clk); #1;
    rd = 1'b0; wr = 1'b1; wdata = 32'd0;
    checks++; if (busy !== 1'b1) begin failures++; $display("FAIL ign_busy got=%b want=1", busy); end
    @(posedge clk); #1;
    wr = 1'b0;
    lat = 1;
    while (done !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++; if (lat !== 3) begin failures++; $display("FAIL ign_latency got=%0d want=3", lat); end
    checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("FAIL ign_rdata got=%h want=deadbeef", rdata); end
    @(posedge clk); #1;
    do_req(1'b1, 1'b0, 32'd5, 32'd0, lat, rv, ev, dn, bz);
    checks++; if (rv !== 32'hDEADBEEF) begin failures++; $display("FAIL ign_no_write got=%h want=deadbeef", rv); end
  endtask

  task automatic test_clear_mid();
    int lat; int dcount; logic [31:0] rv; logic ev, dn, bz;
    do_req(1'b0, 1'b1, 32'd9, 32'h11, lat, rv, ev, dn, bz);
    wr = 1'b1; addr = 32'd9; wdata = 32'hAA;
    @(posedge clk); #1;
    wr = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL clr_state busy=%b done=%b want=0,0", busy, done); end
    dcount = 0;
    repeat (8) begin
      @(posedge clk); #1;
      if (done === 1'b1) dcount++;
    end
    checks++; if (dcount !== 0) begin failures++; $display("FAIL clr_no_done pulses=%0d want=0", dcount); end
    do_req(1'b1, 1'b0, 32'd9, 32'd0, lat, rv, ev, dn, bz);
    checks++; if (rv !== 32'h11) begin failures++; $display("FAIL clr_mem9 got=%h want=11", rv); end
    do_req(1'b0, 1'b1, 32'd3, 32'h55, lat, rv, ev, dn, bz);
    clear = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;
    do_req(1'b1, 1'b0, 32'd3, 32'd0, lat, rv, ev, dn, bz);
    checks++; if (rv !== 32'h55) begin failures++; $display("FAIL clr_keeps_mem3 got=%h want=55", rv); end
  endtask

  task automatic test_clear_priority();
    clear = 1'b1; rd = 1'b1; addr = 32'd5;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL clrpri_accept busy=%b done=%b want=0,0", busy, done); end
    clear = 1'b0; rd = 1'b0;
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL clrpri_queued busy=%b want=0", busy); end
  endtask

  task automatic test_back_to_back();
    logic [11:0] dv, bv;
    logic [31:0] last;
    wr0 = 1'b1; addr0 = 32'd1; wdata0 = 32'h0000ABCD;
    @(posedge clk); #1;
    wr0 = 1'b0;
    checks++; if (busy0 !== 1'b1 || done0 !== 1'b0) begin failures++; $display("FAIL ws0_accept busy=%b done=%b want=1,0", busy0, done0); end
    @(posedge clk); #1;
    checks++; if (done0 !== 1'b1 || err0 !== 1'b0) begin failures++; $display("FAIL ws0_min_latency done=%b err=%b want=1,0", done0, err0); end
    @(posedge clk); #1;
    checks++; if (busy0 !== 1'b0) begin failures++; $display("FAIL ws0_idle busy=%b want=0", busy0); end
    rd0 = 1'b1; addr0 = 32'd1;
    last = 32'hFFFFFFFF;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      dv[i] = done0;
      bv[i] = busy0;
      if (done0 === 1'b1) last = rdata0;
    end
    rd0 = 1'b0;
    checks++; if (dv !== 12'h492) begin failures++; $display("FAIL b2b_done got=%b want=%b", dv, 12'h492); end
    checks++; if (bv !== 12'h6DB) begin failures++; $display("FAIL b2b_busy got=%b want=%b", bv, 12'h6DB); end
    checks++; if (last !== 32'h0000ABCD) begin failures++; $display("FAIL b2b_rdata got=%h want=0000abcd", last); end
    repeat (4) @(posedge clk);
  endtask

  initial begin
    clear = 1'b1;
    rd = 1'b0; wr = 1'b0; addr = 32'd0; wdata = 32'd0;
    rd0 = 1'b0; wr0 = 1'b0; addr0 = 32'd0; wdata0 = 32'd0;
    test_reset();
    test_write_read();
    test_out_of_range();
    test_dual_strobe();
    test_busy_ignore();
    test_clear_mid();
    test_clear_priority();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 512: number of 32-bit words in the internal memory, word-addressed.
REQ-002 SHALL have parameter ADDR_W, default 9: index width, log2(DEPTH).
REQ-003 SHALL have parameter WAIT_STATES, default 2: extra wait cycles per access; legal range 0..15.
REQ-004 SHALL have port clock, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 SHALL have port clear, input, 1 bit: reset, synchronous and active-high.
REQ-006 SHALL have port Read, input, 1 bit: read request strobe from the CPU (initiator).
REQ-007 SHALL have port Write, input, 1 bit: write request strobe from the CPU.
REQ-008 SHALL have port addr, input, 32 bits: word address; driven by the PC for fetch, or by MAR for data.
REQ-009 SHALL have port wdata, input, 32 bits: write data, normally from MDR.
REQ-010 SHALL have port rdata, output, 32 bits, registered: read data returned to MDR or IR.
REQ-011 SHALL have port done, output, 1 bit, registered: one-cycle completion pulse.
REQ-012 SHALL have port busy, output, 1 bit, registered: high while a request is in progress.
REQ-013 SHALL have port err, output, 1 bit, registered: flags a faulted request; valid only while done=1.

Function
REQ-014 SHALL implement an FSM with states IDLE, WAIT, DONE.
REQ-015 SHALL accept a request only in IDLE, at a rising edge where Read=1 xor Write=1:
- latch addr, wdata and operation type;
- load wait counter cnt with WAIT_STATES;
- move to WAIT.
REQ-016 SHALL treat Read=1 and Write=1 together in IDLE as a fault: no memory access, go to DONE with err=1 and rdata=0.
REQ-017 SHALL, in WAIT, decrement cnt at each edge while cnt>0, and perform the access at the edge where cnt=0, then move to DONE.
REQ-018 SHALL, on a write access, store the latched wdata at the latched index.
REQ-019 SHALL, on a read access, load rdata with mem[index].
REQ-020 SHALL treat any latched address >= DEPTH (compared on the full 32 bits) as a fault:
- no write;
- rdata=0;
- err=1 in DONE.
REQ-021 SHALL form the memory index from addr[ADDR_W-1:0] only after the range check has passed.
REQ-022 SHALL hold done=1 for exactly the one cycle spent in DONE, then return to IDLE at the next edge.
REQ-023 SHALL give the following latency: request sampled at edge E0 -> done high in the cycle after edge E0+WAIT_STATES+1.
REQ-024 SHALL have a minimum latency of 2 edges when WAIT_STATES=0.
REQ-025 SHALL drive busy=1 in WAIT and DONE, and busy=0 in IDLE.
REQ-026 SHALL ignore Read/Write in WAIT and DONE: they are neither queued nor able to alter the latched operands.
REQ-027 SHALL accept a request held high through DONE at the first IDLE edge, giving back-to-back accesses with one idle cycle between them.
REQ-028 SHALL hold rdata stable from DONE until the next read access or fault updates it.
REQ-029 SHALL NOT modify rdata on a write access.
REQ-030 SHALL return, on a read of a never-written location, the memory initialisation value (0 in simulation).

Reset
REQ-031 SHALL, at any edge with clear=1, force state=IDLE, cnt=0, rdata=0, done=0, busy=0, err=0.
REQ-032 SHALL give clear priority over any request presented in the same cycle.
REQ-033 SHALL abort an in-flight request when clear is asserted mid-operation:
- a pending write that has not yet reached its access edge SHALL NOT occur;
- no done pulse for the aborted request.
REQ-034 SHALL NOT clear memory contents on clear.

Verification
REQ-035 Write then read, WAIT_STATES=2: Write addr=5, wdata=0xDEADBEEF -> done after edge E0+3, err=0. Then Read addr=5 -> rdata=0xDEADBEEF, done one cycle.
REQ-036 Out of range: Read addr=512 -> done=1, err=1, rdata=0. Write addr=0x80000005, wdata=1 -> err=1, and mem[5] is unchanged on a later read.
REQ-037 Dual strobe: Read=1 and Write=1 addr=7 wdata=0x1234 -> err=1 with done, and mem[7] is unchanged.
REQ-038 Busy-ignore: during WAIT of a Read addr=5, pulse Write addr=5 wdata=0 -> the read returns the old value, and no write occurs.
REQ-039 Reset mid-operation: Write addr=9, wdata=0xAA, clear=1 one edge after acceptance -> busy=0, done never pulses, Read addr=9 returns the prior value. Repeat after writing addr=3=0x55 and asserting clear -> Read addr=3 returns 0x55.
REQ-040 WAIT_STATES=0 back-to-back: hold Read=1 addr=1 -> done pulses every 3 cycles, busy low one cycle between accesses.
